// File: rtl/mem_line_responder.sv
// Memory-side line responder: holds one 128-bit line request for LATENCY cycles, then completes it with a ready pulse.
// Optional protocol checker enabled by defining MEM_PROTO_CHECK_EN (adds proto_err_o).
module mem_line_responder #(
    parameter int LATENCY = 8,
    parameter int DEPTH   = 256,
    parameter int IDX_W   = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read_i,
    input  logic         mem_write_i,
    input  logic [27:0]  mem_addr_i,
    input  logic [127:0] mem_wdata_i,
    output logic [127:0] mem_rdata_o,
    output logic         mem_ready_o
`ifdef MEM_PROTO_CHECK_EN
    ,
    output logic         proto_err_o
`endif
);

    localparam int DATA_W = 128;
    localparam int ADDR_W = 28;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [7:0]          cnt;
    logic                op_wr;
    logic [IDX_W-1:0]    idx_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                req_held;
    logic                req_any;

    logic [DATA_W-1:0]   storage [DEPTH];

    assign req_any  = mem_read_i | mem_write_i;
    assign req_held = op_wr ? mem_write_i : mem_read_i;

    // Control path: write wins when both requests arrive together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            op_wr       <= 1'b0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_ready_o <= 1'b0;
                    if (req_any) begin
                        op_wr <= mem_write_i;
                        cnt   <= 8'(LATENCY - 1);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        state <= IDLE;
                    end else if (cnt == 8'd0) begin
                        state       <= DONE;
                        mem_ready_o <= 1'b1;
                        if (!op_wr) begin
                            mem_rdata_o <= storage[idx_q];
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                DONE: begin
                    mem_ready_o <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    mem_ready_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_PROTO_CHECK_EN
    logic [ADDR_W-1:0] addr_q;
`else
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, mem_addr_i[ADDR_W-1:IDX_W]};
`endif

    // Request payload is captured once at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) begin
            idx_q   <= mem_addr_i[IDX_W-1:0];
            wdata_q <= mem_wdata_i;
`ifdef MEM_PROTO_CHECK_EN
            addr_q  <= mem_addr_i;
`endif
        end
    end

    // Commit happens on the DONE->IDLE edge, ahead of any next acceptance.
    always_ff @(posedge clk) begin
        if (state == DONE && op_wr) begin
            storage[idx_q] <= wdata_q;
        end
    end

`ifdef MEM_PROTO_CHECK_EN
    logic ev_both;
    logic ev_drop;
    logic ev_switch;
    logic ev_addr;

    always_comb begin
        ev_both   = 1'b0;
        ev_drop   = 1'b0;
        ev_switch = 1'b0;
        ev_addr   = 1'b0;
        if (state == IDLE) begin
            ev_both = mem_read_i & mem_write_i;
        end
        if (state == BUSY) begin
            ev_drop   = !req_held;
            ev_switch = op_wr ? mem_read_i : mem_write_i;
            ev_addr   = (mem_addr_i != addr_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            proto_err_o <= 1'b0;
        end else begin
            if (ev_both | ev_drop | ev_switch | ev_addr) begin
                proto_err_o <= 1'b1;
            end
`ifndef SYNTHESIS
            if (ev_both)   $display("[%0t] mem_line_responder warning: read and write both high in IDLE", $time);
            if (ev_drop)   $display("[%0t] mem_line_responder warning: request dropped while BUSY", $time);
            if (ev_switch) $display("[%0t] mem_line_responder warning: op switched while BUSY", $time);
            if (ev_addr)   $display("[%0t] mem_line_responder warning: address changed while BUSY", $time);
`endif
        end
    end
`endif

endmodule
